// File: rtl/featuremap_conv_multi.sv
// Streaming KxK valid-mode 2-D convolution producing NCH feature maps from one
// shared line buffer and window; 3-stage pipeline (window, products, sum/saturate).
module featuremap_conv_multi #(
   parameter int                            DWIDTH  = 16,
   parameter int                            FRAC    = 8,
   parameter int                            IMG_W   = 32,
   parameter int                            IMG_H   = 32,
   parameter int                            K       = 5,
   parameter int                            NCH     = 3,
   parameter logic [NCH*K*K*DWIDTH-1:0]     WEIGHTS = '0,
   parameter logic [NCH*DWIDTH-1:0]         BIAS    = '0,
   parameter int                            RELU    = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [DWIDTH-1:0]       data_in,
   input  logic                    data_valid,
   input  logic                    frame_clear,
   output logic [NCH*DWIDTH-1:0]   data_out,
   output logic                    data_valid_out,
   output logic                    frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int NT = K * K;
   localparam int PW = 2 * DWIDTH;
   localparam int AW = PW + $clog2(NT);
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

   logic [CW-1:0]              col_q, col_d;
   logic [RW-1:0]              row_q, row_d;
   logic                       accept, at_out, at_last;
   logic signed [DWIDTH-1:0]   lb_mem [K-1][IMG_W];
   logic signed [DWIDTH-1:0]   tap [K];
   logic signed [DWIDTH-1:0]   win_q [K][K];
   logic signed [DWIDTH-1:0]   win_d [K][K];
   logic                       v1_q, v1_d, last1_q, last1_d;
   logic                       v2_q, v2_d, last2_q, last2_d;
   logic signed [PW-1:0]       prod_q [NCH][NT];
   logic signed [PW-1:0]       prod_d [NCH][NT];
   logic signed [AW-1:0]       acc [NCH];
   logic signed [AW-1:0]       shifted [NCH];
   logic [NCH*DWIDTH-1:0]      out_q, out_d;
   logic                       vout_q, vout_d, fd_q, fd_d;

   function automatic logic [DWIDTH-1:0] sat_relu(input logic signed [AW-1:0] v);
      logic signed [AW-1:0] s;
      if (v > SAT_MAX)      s = SAT_MAX;
      else if (v < SAT_MIN) s = SAT_MIN;
      else                  s = v;
      if (RELU != 0 && s[AW-1]) s = '0;
      return s[DWIDTH-1:0];
   endfunction

   // A pixel presented together with frame_clear is dropped, not accepted.
   assign accept  = data_valid & ~frame_clear;
   assign at_out  = (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));
   assign at_last = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (frame_clear) begin
         col_d = '0;
         row_d = '0;
      end else if (data_valid) begin
         if (col_q == CW'(IMG_W-1)) begin
            col_d = '0;
            row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // tap[K-1] is the current row; tap[0] is the row K-1 lines above.
   always_comb begin
      tap[K-1] = data_in;
      for (int i = 0; i < K-1; i++) tap[K-2-i] = lb_mem[i][col_q];
   end

   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int r = 0; r < K; r++) begin
            for (int q = 0; q < K-1; q++) win_d[r][q] = win_q[r][q+1];
            win_d[r][K-1] = tap[r];
         end
      end
   end

   always_comb begin
      v1_d    = accept & at_out;
      last1_d = accept & at_last;
      v2_d    = v1_q;
      last2_d = last1_q & v1_q;
      vout_d  = v2_q;
      fd_d    = last2_q;
   end

   always_comb begin
      prod_d = prod_q;
      if (v1_q) begin
         for (int c = 0; c < NCH; c++)
            for (int r = 0; r < K; r++)
               for (int q = 0; q < K; q++)
                  prod_d[c][r*K+q] = PW'(win_q[r][q]) *
                     PW'($signed(WEIGHTS[((c*K+r)*K+q)*DWIDTH +: DWIDTH]));
      end
   end

   // Bias is aligned to the product scale (2*FRAC) before the floor shift.
   always_comb begin
      out_d = out_q;
      for (int c = 0; c < NCH; c++) begin
         acc[c] = AW'($signed(BIAS[c*DWIDTH +: DWIDTH])) <<< FRAC;
         for (int i = 0; i < NT; i++) acc[c] = acc[c] + AW'(prod_q[c][i]);
         shifted[c] = acc[c] >>> FRAC;
         if (v2_q) out_d[c*DWIDTH +: DWIDTH] = sat_relu(shifted[c]);
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         lb_mem[0][col_q] <= data_in;
         for (int i = 1; i < K-1; i++) lb_mem[i][col_q] <= lb_mem[i-1][col_q];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_q   <= '0;
         row_q   <= '0;
         v1_q    <= 1'b0;
         last1_q <= 1'b0;
         v2_q    <= 1'b0;
         last2_q <= 1'b0;
         vout_q  <= 1'b0;
         fd_q    <= 1'b0;
         out_q   <= '0;
         for (int r = 0; r < K; r++)
            for (int q = 0; q < K; q++) win_q[r][q] <= '0;
         for (int c = 0; c < NCH; c++)
            for (int i = 0; i < NT; i++) prod_q[c][i] <= '0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         v1_q    <= v1_d;
         last1_q <= last1_d;
         v2_q    <= v2_d;
         last2_q <= last2_d;
         vout_q  <= vout_d;
         fd_q    <= fd_d;
         out_q   <= out_d;
         win_q   <= win_d;
         prod_q  <= prod_d;
      end
   end

   assign data_out       = out_q;
   assign data_valid_out = vout_q;
   assign frame_done     = fd_q;

endmodule
